// File: rtl/bram_burst_reader.sv
// bram_burst_reader
//   Inferred single-port block RAM with a host write port and a burst-read
//   engine. A burst streams BURST_LEN+1 words starting at START_ADDR over a
//   valid/ready interface. It runs once, or loops until aborted, and it honours
//   backpressure from the consumer.
// Ports
//   clka, rsta_n                     clock (rising edge), async active-low reset
//   wr_en, wr_addr, wr_data          host write; accepted only while idle
//   start, start_addr, burst_len,    burst request, captured on the start edge
//   loop_mode
//   abort                            stop the burst and flush buffered words
//   busy, done, wr_err               status; done and wr_err are 1-cycle pulses
//   out_valid, out_ready,            output stream; out_addr is the address
//   out_data, out_addr               that out_data was read from
module bram_burst_reader #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic              loop_mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q;

  logic [ADDR_W-1:0] base_q, len_q, iss_addr, iss_cnt, rd_addr_q;
  logic              loop_q, rd_vld;
  logic [ADDR_W:0]   acc_cnt;   // words accepted; needs one extra bit for full-RAM bursts
  word_t             buf0, buf1, rd_word;
  logic [1:0]        cnt;       // buffered words, 0..2
  logic [1:0]        occ;
  logic              pop, issue, last_iss, wr_fire, last_acc;

  assign busy      = (state != S_IDLE);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = buf0.data;
  assign out_addr  = buf0.addr;
  assign pop       = out_valid & out_ready;
  assign wr_fire   = wr_en & (state == S_IDLE);
  assign rd_word   = '{addr: rd_addr_q, data: ram_q};
  assign last_iss  = (iss_cnt == len_q);
  assign last_acc  = ((acc_cnt + {{ADDR_W{1'b0}}, pop}) == ({1'b0, len_q} + 1'b1));

  // Occupancy the buffer will have after this edge. A word accepted this cycle
  // frees its slot in time for the read issued now, which is what allows one
  // word per cycle while a 2-entry buffer still never overflows.
  assign occ   = cnt + {1'b0, rd_vld} - {1'b0, pop};
  assign issue = (state == S_READ) && !abort && (occ < 2'd2);

  // RAM: write port only used while idle, read port only while reading, so a
  // single physical port is enough.
  always_ff @(posedge clka) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
    if (issue)   ram_q <= mem[iss_addr];
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (abort) state_nx = S_IDLE;
               else if (issue && last_iss && !loop_q) state_nx = S_DRAIN;
      // leave on the edge that accepts the final word, so done and the
      // falling busy coincide with it
      S_DRAIN: if (abort || (pop && last_acc)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      done      <= 1'b0;
      wr_err    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      iss_addr  <= '0;
      iss_cnt   <= '0;
      acc_cnt   <= '0;
      rd_vld    <= 1'b0;
      rd_addr_q <= '0;
      buf0      <= '0;
      buf1      <= '0;
      cnt       <= 2'd0;
    end else begin
      done   <= (state == S_DRAIN) && !abort && (state_nx == S_IDLE);
      wr_err <= wr_en & busy;

      if (state == S_IDLE) begin
        if (start) begin
          base_q   <= start_addr;
          len_q    <= burst_len;
          loop_q   <= loop_mode;
          iss_addr <= start_addr;
          iss_cnt  <= '0;
          acc_cnt  <= '0;
        end
      end else begin
        if (issue) begin
          if (last_iss) begin
            iss_addr <= base_q;
            iss_cnt  <= '0;
          end else begin
            iss_addr <= iss_addr + 1'b1;
            iss_cnt  <= iss_cnt + 1'b1;
          end
        end
        if (pop) acc_cnt <= acc_cnt + 1'b1;
      end

      rd_vld <= issue;
      if (issue) rd_addr_q <= iss_addr;

      if (abort && busy) begin
        cnt <= 2'd0;            // in-flight read is dropped via rd_vld <= issue (0)
      end else begin
        case ({rd_vld, pop})
          2'b10: begin
            if (cnt == 2'd0) buf0 <= rd_word;
            else             buf1 <= rd_word;
            cnt <= cnt + 1'b1;
          end
          2'b01: begin
            buf0 <= buf1;
            cnt  <= cnt - 1'b1;
          end
          2'b11: begin
            if (cnt == 2'd1) buf0 <= rd_word;
            else begin
              buf0 <= buf1;
              buf1 <= rd_word;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// tb_bram_burst_reader
//   Directed-plus-random bench for bram_burst_reader (DATA_W=8, ADDR_W=8).
//   A reference memory image and per-burst expected address lists are kept
//   here; accepted words are checked against them as they are consumed.
module tb_bram_burst_reader;

  logic       clka, rsta_n;
  logic       wr_en, start, loop_mode, abort, out_ready;
  logic [7:0] wr_addr, wr_data, start_addr, burst_len;
  logic       busy, done, wr_err, out_valid;
  logic [7:0] out_data, out_addr;

  logic [7:0] ref_mem [0:255];
  int checks = 0;
  int errors = 0;

  bram_burst_reader #(.DATA_W(8), .ADDR_W(8), .INIT_FILE("")) dut (
    .clka(clka), .rsta_n(rsta_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_addr(start_addr), .burst_len(burst_len),
    .loop_mode(loop_mode), .abort(abort),
    .busy(busy), .done(done), .wr_err(wr_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One non-looping burst. Expected addresses are start + i (mod 256),
  // expected data comes from the reference image.
  task automatic do_burst(input logic [7:0] sa, input logic [7:0] bl,
                          input bit rnd, input bit wr_same);
    logic [7:0] q[$];
    logic [7:0] tmp, sd, sadr;
    int got, cyc, first_v;
    bit stalled;
    got = 0; cyc = 0; first_v = -1; stalled = 0; sd = 0; sadr = 0;
    for (int i = 0; i <= int'(bl); i++) begin
      tmp = sa + 8'(i);
      q.push_back(tmp);
    end
    start = 1'b1; start_addr = sa; burst_len = bl; loop_mode = 1'b0;
    if (wr_same) begin
      wr_en = 1'b1; wr_addr = sa; wr_data = 8'($urandom);
      ref_mem[sa] = wr_data;
    end
    out_ready = 1'b1;
    tick();
    // request fields change after the start edge; the burst must ignore them
    start = 1'b0; wr_en = 1'b0;
    start_addr = 8'($urandom); burst_len = 8'($urandom); loop_mode = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (got <= int'(bl) && cyc < 2000) begin
      if (first_v < 0 && out_valid) first_v = cyc;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(sd));
        chk("stall_addr", 32'(out_addr), 32'(sadr));
      end
      chk("no_early_done", 32'(done), 32'd0);
      if (out_valid && out_ready) begin
        tmp = q.pop_front();
        chk("burst_addr", 32'(out_addr), 32'(tmp));
        chk("burst_data", 32'(out_data), 32'(ref_mem[tmp]));
        got++;
      end
      stalled = out_valid && !out_ready;
      sd = out_data; sadr = out_addr;
      tick();
      cyc++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    loop_mode = 1'b0;
    chk("word_count", 32'(got), 32'(int'(bl) + 1));
    if (!rnd) begin
      chk("first_latency", 32'(first_v), 32'd2);
      chk("throughput", 32'(cyc), 32'(int'(bl) + 3));
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(out_valid), 32'd0);
    tick();
    chk("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] tmp;
    int n, cyc;
    wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; start_addr = 0;
    burst_len = 0; loop_mode = 0; abort = 0; out_ready = 0;
    rsta_n = 1'b1;
    #1 rsta_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    tick(); tick();
    rsta_n = 1'b1;
    tick();

    for (int i = 0; i < 256; i++) host_wr(8'(i), 8'(i) ^ 8'hA5);

    do_burst(8'h02, 8'd3, 0, 0);                     // A7,A6,A1,A0
    do_burst(8'hFE, 8'd3, 0, 0);                     // address wrap
    do_burst(8'h77, 8'd0, 0, 0);                     // single word
    do_burst(8'($urandom), 8'd63, 1, 0);             // backpressure
    do_burst(8'($urandom), 8'd63, 1, 0);
    do_burst(8'($urandom), 8'd255, 1, 0);            // whole RAM once

    // loop mode with a dropped write and an ignored start mid-burst
    start = 1'b1; start_addr = 8'h0A; burst_len = 8'd1; loop_mode = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; loop_mode = 1'b0;
    n = 0; cyc = 0;
    while (n < 12 && cyc < 300) begin
      chk("loop_no_done", 32'(done), 32'd0);
      if (cyc == 6) chk("wr_err_pulse", 32'(wr_err), 32'd1);
      if (cyc == 7) chk("wr_err_once", 32'(wr_err), 32'd0);
      if (cyc == 5) begin
        wr_en = 1'b1; wr_addr = 8'h0A; wr_data = ~ref_mem[8'h0A];
        start = 1'b1; start_addr = 8'h80;
      end
      if (out_valid && out_ready) begin
        tmp = 8'h0A + 8'(n % 2);
        chk("loop_addr", 32'(out_addr), 32'(tmp));
        chk("loop_data", 32'(out_data), 32'(ref_mem[tmp]));
        n++;
      end
      tick();
      cyc++;
      wr_en = 1'b0; start = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("loop_count", 32'(n), 32'd12);
    chk("loop_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle_valid", 32'(out_valid), 32'd0);
    end

    do_burst(8'h0A, 8'd1, 0, 0);                     // dropped write left RAM intact
    do_burst(8'h30, 8'd3, 0, 1);                     // start+write same cycle

    // asynchronous reset in the middle of a burst
    start = 1'b1; start_addr = 8'h20; burst_len = 8'd63; loop_mode = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(out_valid), 32'd1);
    #2 rsta_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick();
    rsta_n = 1'b1;
    tick();
    do_burst(8'h20, 8'd7, 1, 0);                     // RAM kept its contents

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
